// File: rtl/ddr2_sys_st_pkg.sv
// Shared marker bytes and FSM state type for the ddr2_sys Avalon-ST byte-path adapters.
package ddr2_sys_st_pkg;

  localparam logic [7:0] SOP_MK  = 8'h7A;
  localparam logic [7:0] EOP_MK  = 8'h7B;
  localparam logic [7:0] CH_MK   = 8'h7C;
  localparam logic [7:0] ESC_MK  = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;

  typedef enum logic [2:0] {
    StIdle,
    StChEsc,
    StChVal,
    StSopMk,
    StEopMk,
    StDataEsc,
    StDataVal
  } p2b_state_e;

endpackage

// File: rtl/ddr2_sys_p2b_escape.sv
// Flags bytes that collide with an in-band marker and produces the value sent after ESC_MK.
module ddr2_sys_p2b_escape
  import ddr2_sys_st_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       need_esc_o,
  output logic [7:0] esc_byte_o
);

  always_comb begin
    need_esc_o = (byte_i >= SOP_MK) && (byte_i <= ESC_MK);
    esc_byte_o = need_esc_o ? (byte_i ^ ESC_XOR) : byte_i;
  end

endmodule

// File: rtl/ddr2_sys_packets_to_bytes.sv
// Serialises channelised Avalon-ST packet beats into an escaped byte stream with in-band
// SOP/EOP/channel markers. One registered output slot; input is accepted only from idle.
module ddr2_sys_packets_to_bytes
  import ddr2_sys_st_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH       = 8,
  parameter bit          EMIT_CHANNEL_ALWAYS = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  p2b_state_e state_q, state_d;

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [7:0] last_ch_q;
  logic       ch_known_q;
  logic [7:0] data_q;
  logic [7:0] ch_q;
  logic       sop_q;
  logic       eop_q;

  logic       is_idle;
  logic       slot_free;
  logic       accept;
  logic       need_ch;
  logic       load;
  logic [7:0] emit_byte;
  logic [7:0] in_ch_ext;
  logic [7:0] data_src;
  logic [7:0] ch_src;
  logic       data_need_esc;
  logic [7:0] data_esc;
  logic       ch_need_esc;
  logic [7:0] ch_esc;
  p2b_state_e data_next;

  always_comb begin
    in_ch_ext = '0;
    in_ch_ext[CHANNEL_WIDTH-1:0] = in_channel;
  end

  assign is_idle   = (state_q == StIdle);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = is_idle && slot_free;
  assign accept    = in_valid && in_ready;

  assign need_ch = in_startofpacket &&
                   (EMIT_CHANNEL_ALWAYS || !ch_known_q || (in_ch_ext != last_ch_q));

  // In idle the escape decision is made on the live beat; afterwards on the held copy.
  assign data_src = is_idle ? in_data : data_q;
  assign ch_src   = is_idle ? in_ch_ext : ch_q;

  ddr2_sys_p2b_escape u_data_esc (
    .byte_i     (data_src),
    .need_esc_o (data_need_esc),
    .esc_byte_o (data_esc)
  );

  ddr2_sys_p2b_escape u_ch_esc (
    .byte_i     (ch_src),
    .need_esc_o (ch_need_esc),
    .esc_byte_o (ch_esc)
  );

  assign data_next = data_need_esc ? StDataEsc : StDataVal;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (need_ch) begin
            state_d = ch_need_esc ? StChEsc : StChVal;
          end else if (in_startofpacket) begin
            state_d = in_endofpacket ? StEopMk : data_next;
          end else if (in_endofpacket) begin
            state_d = data_next;
          end else begin
            state_d = data_need_esc ? StDataVal : StIdle;
          end
        end
      end
      StChEsc: begin
        if (slot_free) state_d = StChVal;
      end
      StChVal: begin
        if (slot_free) state_d = sop_q ? StSopMk : (eop_q ? StEopMk : data_next);
      end
      StSopMk: begin
        if (slot_free) state_d = eop_q ? StEopMk : data_next;
      end
      StEopMk: begin
        if (slot_free) state_d = data_next;
      end
      StDataEsc: begin
        if (slot_free) state_d = StDataVal;
      end
      StDataVal: begin
        if (slot_free) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    emit_byte = data_esc;
    unique case (state_q)
      StIdle: begin
        load = accept;
        if (need_ch) begin
          emit_byte = CH_MK;
        end else if (in_startofpacket) begin
          emit_byte = SOP_MK;
        end else if (in_endofpacket) begin
          emit_byte = EOP_MK;
        end else if (data_need_esc) begin
          emit_byte = ESC_MK;
        end else begin
          emit_byte = data_esc;
        end
      end
      StChEsc: begin
        load      = slot_free;
        emit_byte = ESC_MK;
      end
      StChVal: begin
        load      = slot_free;
        emit_byte = ch_esc;
      end
      StSopMk: begin
        load      = slot_free;
        emit_byte = SOP_MK;
      end
      StEopMk: begin
        load      = slot_free;
        emit_byte = EOP_MK;
      end
      StDataEsc: begin
        load      = slot_free;
        emit_byte = ESC_MK;
      end
      StDataVal: begin
        load      = slot_free;
        emit_byte = data_esc;
      end
      default: begin
        load      = 1'b0;
        emit_byte = data_esc;
      end
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_byte;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      last_ch_q   <= 8'h00;
      ch_known_q  <= 1'b0;
      data_q      <= 8'h00;
      ch_q        <= 8'h00;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (accept) begin
        data_q <= in_data;
        ch_q   <= in_ch_ext;
        sop_q  <= in_startofpacket;
        eop_q  <= in_endofpacket;
        if (need_ch) begin
          last_ch_q  <= in_ch_ext;
          ch_known_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_ddr2_sys_packets_to_bytes.sv
// Directed and randomised-backpressure checks of the packet-to-byte serialiser.
module tb_ddr2_sys_packets_to_bytes;

  logic       clk = 1'b0;
  logic       reset_n;

  logic       in_ready, in_valid, in_sop, in_eop, out_ready, out_valid;
  logic [7:0] in_data, in_channel, out_data;

  logic       b_in_ready, b_in_valid, b_in_sop, b_in_eop, b_out_ready, b_out_valid;
  logic [7:0] b_in_data, b_in_channel, b_out_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_acc;
  bit         rnd_on;
  logic [7:0] mon_q[$];
  logic [7:0] mon_b_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr2_sys_packets_to_bytes #(
    .CHANNEL_WIDTH       (8),
    .EMIT_CHANNEL_ALWAYS (1'b0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_sop),
    .in_endofpacket   (in_eop),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  ddr2_sys_packets_to_bytes #(
    .CHANNEL_WIDTH       (8),
    .EMIT_CHANNEL_ALWAYS (1'b1)
  ) dut_always (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_ready         (b_in_ready),
    .in_valid         (b_in_valid),
    .in_data          (b_in_data),
    .in_channel       (b_in_channel),
    .in_startofpacket (b_in_sop),
    .in_endofpacket   (b_in_eop),
    .out_ready        (b_out_ready),
    .out_valid        (b_out_valid),
    .out_data         (b_out_data)
  );

  // Handshake values seen at the falling edge are the ones the next rising edge uses.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) mon_q.push_back(out_data);
    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) mon_b_q.push_back(b_out_data);
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Called and returns at posedge+1; back-to-back calls give one beat per clock.
  task automatic send_beat(input bit which, input logic [7:0] d, input logic [7:0] ch,
                           input logic sop, input logic eop);
    bit done;
    done = 1'b0;
    if (which) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_channel = ch; b_in_sop = sop; b_in_eop = eop;
    end else begin
      in_valid = 1'b1; in_data = d; in_channel = ch; in_sop = sop; in_eop = eop;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = which ? (b_in_ready === 1'b1) : (in_ready === 1'b1);
      @(posedge clk); #1;
    end
    if (which) b_in_valid = 1'b0;
    else in_valid = 1'b0;
    last_acc = cyc;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_beat: beat %02h not accepted within 200 cycles, want accept", d);
    end
  endtask

  task automatic wait_bytes(input bit which, input int n);
    for (int i = 0; i < n * 8 + 50; i++) begin
      @(negedge clk);
      if ((which ? mon_b_q.size() : mon_q.size()) >= n) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1; b_out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++; if (out_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_out_data: got %02h want 00", out_data);
    end
    n_cmp++; if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_cmp++; if (b_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_first_packet();
    logic [7:0] exp[$];
    int low;
    int acc0;
    mon_q.delete();
    send_beat(0, 8'h11, 8'h00, 1'b1, 1'b0);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      low++;
    end
    n_cmp++; if (low != 3) begin
      n_bad++; $display("FAIL first_in_ready_low: got %0d cycles want 3", low);
    end
    @(posedge clk); #1;
    send_beat(0, 8'h22, 8'h00, 1'b0, 1'b0);
    acc0 = last_acc;
    send_beat(0, 8'h23, 8'h00, 1'b0, 1'b0);
    send_beat(0, 8'h24, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (last_acc - acc0 != 2) begin
      n_bad++; $display("FAIL stream_rate: got %0d cycles for 3 beats want 2", last_acc - acc0);
    end
    exp = '{8'h7C, 8'h00, 8'h7A, 8'h11, 8'h22, 8'h23, 8'h24};
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL first_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL first_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_same_channel();
    logic [7:0] exp[$];
    mon_q.delete();
    send_beat(0, 8'h33, 8'h00, 1'b1, 1'b0);
    send_beat(0, 8'h34, 8'h00, 1'b0, 1'b1);
    exp = '{8'h7A, 8'h33, 8'h7B, 8'h34};
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL samech_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL samech_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_emit_always();
    logic [7:0] exp[$];
    mon_b_q.delete();
    send_beat(1, 8'h33, 8'h00, 1'b1, 1'b0);
    send_beat(1, 8'h33, 8'h00, 1'b1, 1'b0);
    exp = '{8'h7C, 8'h00, 8'h7A, 8'h33, 8'h7C, 8'h00, 8'h7A, 8'h33};
    wait_bytes(1, exp.size());
    n_cmp++; if (mon_b_q.size() != exp.size()) begin
      n_bad++; $display("FAIL always_len: got %0d want %0d", mon_b_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_b_q.size() || mon_b_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL always_byte[%0d]: got %02h want %02h", i, mon_b_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_escape();
    logic [7:0] exp[$];
    mon_q.delete();
    send_beat(0, 8'h7A, 8'h00, 1'b0, 1'b0);
    send_beat(0, 8'h7D, 8'h00, 1'b0, 1'b0);
    send_beat(0, 8'h7C, 8'h00, 1'b0, 1'b0);
    send_beat(0, 8'h7E, 8'h00, 1'b0, 1'b0);
    send_beat(0, 8'h01, 8'h7B, 1'b1, 1'b0);
    send_beat(0, 8'h02, 8'h55, 1'b0, 1'b0);
    exp = '{8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7D, 8'h5C, 8'h7E,
            8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h01, 8'h02};
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL esc_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL esc_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_single_beat();
    logic [7:0] exp[$];
    mon_q.delete();
    send_beat(0, 8'h7B, 8'h03, 1'b1, 1'b1);
    send_beat(0, 8'h7A, 8'h7D, 1'b1, 1'b1);
    exp = '{8'h7C, 8'h03, 8'h7A, 8'h7B, 8'h7D, 8'h5B,
            8'h7C, 8'h7D, 8'h5D, 8'h7A, 8'h7B, 8'h7D, 8'h5A};
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL single_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL single_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[$];
    mon_q.delete();
    send_beat(0, 8'h7C, 8'h05, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h7C) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%02h want v=1 d=7C", i, out_valid, out_data);
      end
      n_cmp++; if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp = '{8'h7C, 8'h05, 8'h7A, 8'h7D, 8'h5C};
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL bp_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL bp_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    send_beat(0, 8'h44, 8'h09, 1'b1, 1'b0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h7C) begin
      n_bad++; $display("FAIL rstmid_pre: got v=%b d=%02h want v=1 d=7C", out_valid, out_data);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid);
    end
    n_cmp++; if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_idle: got in_ready=%b want 1", in_ready);
    end
    reset_n = 1'b1;
    mon_q.delete();
    mon_b_q.delete();
    send_beat(0, 8'h55, 8'h00, 1'b1, 1'b0);
    exp = '{8'h7C, 8'h00, 8'h7A, 8'h55};
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL rstmid_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL rstmid_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] d, ch, last;
    logic       sop, eop;
    bit         known;
    out_ready = 1'b1;
    do_reset();
    mon_q.delete();
    known = 1'b0;
    last  = 8'h00;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int n = 0; n < 1000; n++) begin
      d   = ($urandom_range(0, 3) == 0) ? 8'(8'h79 + $urandom_range(0, 5))
                                        : 8'($urandom_range(0, 255));
      ch  = ($urandom_range(0, 3) == 0) ? 8'(8'h7A + $urandom_range(0, 3))
                                        : 8'($urandom_range(0, 7));
      sop = ($urandom_range(0, 3) == 0);
      eop = ($urandom_range(0, 3) == 0);
      if (sop && (!known || ch != last)) begin
        exp.push_back(8'h7C);
        if (ch >= 8'h7A && ch <= 8'h7D) begin
          exp.push_back(8'h7D); exp.push_back(ch ^ 8'h20);
        end else begin
          exp.push_back(ch);
        end
        known = 1'b1;
        last  = ch;
      end
      if (sop) exp.push_back(8'h7A);
      if (eop) exp.push_back(8'h7B);
      if (d >= 8'h7A && d <= 8'h7D) begin
        exp.push_back(8'h7D); exp.push_back(d ^ 8'h20);
      end else begin
        exp.push_back(d);
      end
      send_beat(0, d, ch, sop, eop);
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_bytes(0, exp.size());
    n_cmp++; if (mon_q.size() != exp.size()) begin
      n_bad++; $display("FAIL rand_len: got %0d want %0d", mon_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++; if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
        n_bad++; $display("FAIL rand_byte[%0d]: got %02h want %02h", i, mon_q[i], exp[i]);
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_channel = 8'h00; in_sop = 1'b0; in_eop = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_in_channel = 8'h00; b_in_sop = 1'b0;
    b_in_eop = 1'b0;
    out_ready = 1'b1; b_out_ready = 1'b1;
    rnd_on = 1'b0;
    last_acc = 0;
    test_reset();
    test_first_packet();
    test_same_channel();
    test_emit_always();
    test_escape();
    test_single_beat();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ddr2_sys_packets_to_bytes.md
Name: ddr2_sys_packets_to_bytes

Overview:
Converts the channelised Avalon-ST packet stream from the master's packet-to-bytes channel adapter into a flat escaped byte stream for the JTAG byte path. Packet boundaries and channel numbers become in-band marker bytes: SOP 0x7A, EOP 0x7B, CHANNEL 0x7C, ESCAPE 0x7D. It sits directly downstream of the channel adapter and upstream of the byte-level timing adapter/PHY in the ddr2_sys master.

Parameters:
CHANNEL_WIDTH, 8, width of in_channel (1..8); zero-extended to 8 bits when emitted.
EMIT_CHANNEL_ALWAYS, 0, 1 = emit the channel sequence on every SOP; 0 = only when the channel differs from the last one sent.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset_n  input  1  synchronous, active-low reset
in_ready  output  1  Avalon-ST sink ready (combinational)
in_valid  input  1  sink valid
in_data  input  8  sink payload byte
in_channel  input  CHANNEL_WIDTH  channel; sampled only on SOP beats
in_startofpacket  input  1  sink SOP
in_endofpacket  input  1  sink EOP
out_ready  input  1  source ready
out_valid  output  1  source valid (registered)
out_data  output  8  source byte (registered)

Behaviour:
- Reset (sync, reset_n=0 at a clk edge): out_valid=0, out_data=0x00, FSM=IDLE, last_ch=0, ch_known=0, holding registers cleared. Pending bytes are discarded. Reset wins over every other event in that cycle.
- Output slot: single register. slot_free = !out_valid || out_ready. While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- in_ready = (state==IDLE) && slot_free. Accept = in_valid && in_ready.
- Per accepted beat, the emitted byte sequence is, in order:
  - If SOP and (EMIT_CHANNEL_ALWAYS || !ch_known || ch != last_ch): 0x7C, then the escaped channel byte.
  - If SOP: 0x7A.
  - If EOP: 0x7B.
  - The escaped data byte.
- Escape rule: any byte in 0x7A..0x7D is sent as 0x7D followed by (byte XOR 0x20). This applies to both channel and data bytes.
- On accept, the first byte of the sequence is loaded into out_data in the same cycle, so out_valid rises on the next edge (latency 1). Remaining fields are captured into holding registers (data, channel, sop, eop, need_ch).
- If the sequence is a single byte, the FSM stays IDLE. Plain data therefore streams at 1 byte/clk with out_ready=1.
- FSM states: IDLE, CH_ESC, CH_VAL, SOP_MK, EOP_MK, DATA_ESC, DATA_VAL.
  - Each non-IDLE state loads its byte when slot_free, then advances to the next required state, skipping absent items.
  - The final byte returns the FSM to IDLE.
  - CH_ESC is entered only if the channel needs escaping; otherwise the FSM goes straight to CH_VAL. DATA_ESC follows the same rule.
- last_ch<=ch and ch_known<=1 are updated on accept of a beat that emits the channel sequence.
- in_channel is ignored on non-SOP beats.
- A single-beat packet (SOP=EOP=1) emits both markers.
- EOP without a prior SOP, or SOP mid-packet, is passed through as markers; no error checking.
- Worst-case beat is 7 bytes: 7C, 7D, ch^20, 7A, 7B, 7D, d^20.

Decomposition:
- Shared package ddr2_sys_st_pkg holds:
  - marker constants SOP_MK=8'h7A, EOP_MK=8'h7B, CH_MK=8'h7C, ESC_MK=8'h7D, ESC_XOR=8'h20;
  - the FSM state enum.
- One combinational sub-module, ddr2_sys_p2b_escape: input byte -> need_esc flag and escaped value. It is instantiated for data and for channel.

Test Plan:
1. Reset, then beat SOP=1, EOP=0, ch=0, data=0x11 -> bytes 7C 00 7A 11. in_ready is low for 3 cycles. Next beat data=0x22 (no SOP/EOP) -> 22 at 1 byte/clk.
2. Second packet on the same channel 0: SOP, data=0x33 -> 7A 33 (no channel sequence). With EMIT_CHANNEL_ALWAYS=1 -> 7C 00 7A 33.
3. Escape: data beats 0x7A, 0x7D, 0x7C, 0x7E -> 7D 5A, 7D 5D, 7D 5C, 7E. SOP on ch=0x7B -> 7C 7D 5B 7A ...
4. Single-beat packet SOP=EOP=1, ch=3, data=0x7B -> 7C 03 7A 7B 7D 5B (7 bytes max case exercised with ch=0x7D).
5. Backpressure: hold out_ready=0 for 5 cycles mid-sequence -> out_data/out_valid stable, in_ready=0, no byte lost or duplicated. Random out_ready at 50% over 1000 beats -> a decoder scoreboard matches the input stream.
6. Assert reset_n=0 mid-sequence (after 7C sent) -> next cycle out_valid=0, FSM IDLE. Next SOP on ch=0 re-emits 7C 00 (ch_known cleared).
